// File: rtl/alu_multiciclo.sv
// Multi-cycle MIPS execution unit: single-cycle logic/add/sub/slt, iterative
// shift-add multiply and restoring divide, with an inicio/listo handshake.
module alu_multiciclo #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inicio,
   input  logic [3:0]       control,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] resultado,
   output logic [WIDTH-1:0] resto,
   output logic             cero,
   output logic             div_cero,
   output logic             ocupado,
   output logic             listo
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_SLT = 4'b0111;
   localparam logic [3:0] OP_XOR = 4'b0101;
   localparam logic [3:0] OP_NOR = 4'b1100;
   localparam logic [3:0] OP_MUL = 4'b1000;
   localparam logic [3:0] OP_DIV = 4'b1010;

   typedef enum logic [1:0] {REPOSO, MUL, DIV, FIN} estado_t;

   estado_t          estado_q, estado_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH:0]   acc_q, acc_d;
   logic [WIDTH-1:0] opa_q, opa_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic [WIDTH-1:0] resultado_q, resultado_d;
   logic [WIDTH-1:0] resto_q, resto_d;
   logic             cero_q, cero_d;
   logic             div_cero_q, div_cero_d;

   logic             acepta, es_mul, es_div, b_cero, ultimo;
   logic [WIDTH:0]   mul_sum, rem_shift, rem_next;
   logic [WIDTH-1:0] quo_next, res_simple;

   function automatic logic [WIDTH-1:0] alu_simple(input logic [3:0] op,
                                                   input logic [WIDTH-1:0] x,
                                                   input logic [WIDTH-1:0] y);
      logic signed [WIDTH-1:0] xs;
      logic signed [WIDTH-1:0] ys;
      logic [WIDTH-1:0]        r;
      xs = x;
      ys = y;
      case (op)
         OP_ADD:  r = x + y;
         OP_SUB:  r = x - y;
         OP_AND:  r = x & y;
         OP_OR:   r = x | y;
         OP_SLT:  r = (xs < ys) ? WIDTH'(1) : '0;
         OP_XOR:  r = x ^ y;
         OP_NOR:  r = ~(x | y);
         default: r = '0;
      endcase
      return r;
   endfunction

   assign acepta = inicio && ((estado_q == REPOSO) || (estado_q == FIN));
   assign es_mul = (control == OP_MUL);
   assign es_div = (control == OP_DIV);
   assign b_cero = (b == '0);
   assign ultimo = (cnt_q == CNT_W'(1));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) estado_q <= REPOSO;
      else        estado_q <= estado_d;
   end

   // Next-state logic
   always_comb begin
      estado_d = estado_q;
      case (estado_q)
         REPOSO, FIN: begin
            if (inicio) begin
               if (es_mul)                estado_d = MUL;
               else if (es_div && !b_cero) estado_d = DIV;
               else                       estado_d = FIN;
            end else begin
               estado_d = REPOSO;
            end
         end
         MUL, DIV: if (ultimo) estado_d = FIN;
         default:  estado_d = REPOSO;
      endcase
   end

   // Handshake outputs are pure functions of the state, so they can never overlap
   always_comb begin
      ocupado = (estado_q == MUL) || (estado_q == DIV);
      listo   = (estado_q == FIN);
   end

   always_comb begin
      acc_d       = acc_q;
      opa_d       = opa_q;
      opb_d       = opb_q;
      cnt_d       = cnt_q;
      resultado_d = resultado_q;
      resto_d     = resto_q;
      cero_d      = cero_q;
      div_cero_d  = div_cero_q;
      res_simple  = alu_simple(control, a, b);
      mul_sum     = acc_q + (opb_q[0] ? {1'b0, opa_q} : '0);
      // Restoring divide: opa_q holds the dividend shifting out and the quotient shifting in
      rem_shift   = {acc_q[WIDTH-1:0], opa_q[WIDTH-1]};
      if (rem_shift >= {1'b0, opb_q}) begin
         rem_next = rem_shift - {1'b0, opb_q};
         quo_next = {opa_q[WIDTH-2:0], 1'b1};
      end else begin
         rem_next = rem_shift;
         quo_next = {opa_q[WIDTH-2:0], 1'b0};
      end

      if (acepta) begin
         if (es_mul || (es_div && !b_cero)) begin
            acc_d = '0;
            opa_d = a;
            opb_d = b;
            cnt_d = CNT_W'(WIDTH);
         end else if (es_div) begin
            resultado_d = '1;
            resto_d     = a;
            cero_d      = 1'b0;
            div_cero_d  = 1'b1;
         end else begin
            resultado_d = res_simple;
            resto_d     = '0;
            cero_d      = (res_simple == '0);
            div_cero_d  = 1'b0;
         end
      end else if (estado_q == MUL) begin
         acc_d = mul_sum;
         opa_d = opa_q << 1;
         opb_d = opb_q >> 1;
         cnt_d = cnt_q - CNT_W'(1);
         if (ultimo) begin
            resultado_d = mul_sum[WIDTH-1:0];
            resto_d     = '0;
            cero_d      = (mul_sum[WIDTH-1:0] == '0);
            div_cero_d  = 1'b0;
         end
      end else if (estado_q == DIV) begin
         acc_d = rem_next;
         opa_d = quo_next;
         cnt_d = cnt_q - CNT_W'(1);
         if (ultimo) begin
            resultado_d = quo_next;
            resto_d     = rem_next[WIDTH-1:0];
            cero_d      = (quo_next == '0);
            div_cero_d  = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         resultado_q <= '0;
         resto_q     <= '0;
         cero_q      <= 1'b0;
         div_cero_q  <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         resultado_q <= resultado_d;
         resto_q     <= resto_d;
         cero_q      <= cero_d;
         div_cero_q  <= div_cero_d;
      end
   end

   // Iteration datapath is only meaningful after a load, so it carries no reset
   always_ff @(posedge clk) begin
      acc_q <= acc_d;
      opa_q <= opa_d;
      opb_q <= opb_d;
   end

   assign resultado = resultado_q;
   assign resto     = resto_q;
   assign cero      = cero_q;
   assign div_cero  = div_cero_q;

endmodule

// File: tb/tb_alu_multiciclo.sv
// Table-driven bench for alu_multiciclo plus hand-written multi-cycle sequences.
module tb_alu_multiciclo;

   logic        clk;
   logic        rst_n;
   logic        inicio;
   logic [3:0]  control;
   logic [31:0] a, b;
   logic [31:0] resultado, resto;
   logic        cero, div_cero, ocupado, listo;

   int nvec  = 0;
   int nfail = 0;

   alu_multiciclo #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .inicio(inicio), .control(control),
      .a(a), .b(b), .resultado(resultado), .resto(resto), .cero(cero),
      .div_cero(div_cero), .ocupado(ocupado), .listo(listo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  ctrl;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic [31:0] rem;
      logic        cero;
      logic        dz;
      int          lat;
   } vec_t;

   vec_t vecs[18];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int lat;
      int occ;
      logic both;
      @(negedge clk);
      control = v.ctrl; a = v.a; b = v.b; inicio = 1'b1;
      lat = 0; occ = 0; both = 1'b0;
      do begin
         @(posedge clk); #1;
         inicio = 1'b0;
         lat++;
         if (ocupado) occ++;
         if (ocupado && listo) both = 1'b1;
      end while (!listo && lat < 100);
      chk($sformatf("v%0d_lat", idx), lat, v.lat);
      chk($sformatf("v%0d_res", idx), resultado, v.res);
      chk($sformatf("v%0d_resto", idx), resto, v.rem);
      chk($sformatf("v%0d_cero", idx), {31'b0, cero}, {31'b0, v.cero});
      chk($sformatf("v%0d_divcero", idx), {31'b0, div_cero}, {31'b0, v.dz});
      chk($sformatf("v%0d_ocupado_cycles", idx), occ, (v.lat == 33) ? 32 : 0);
      chk($sformatf("v%0d_overlap", idx), {31'b0, both}, 32'd0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_listo_drop", idx), {31'b0, listo}, 32'd0);
   endtask

   initial begin
      int lat;
      int occ;
      int pulses;
      logic both;

      vecs[0]  = '{4'b0010, 32'd7,          32'd5,          32'd12,         32'd0,   1'b0, 1'b0, 1};
      vecs[1]  = '{4'b0110, 32'd5,          32'd5,          32'd0,          32'd0,   1'b1, 1'b0, 1};
      vecs[2]  = '{4'b0111, 32'hFFFFFFFF,   32'd1,          32'd1,          32'd0,   1'b0, 1'b0, 1};
      vecs[3]  = '{4'b1100, 32'd0,          32'd0,          32'hFFFFFFFF,   32'd0,   1'b0, 1'b0, 1};
      vecs[4]  = '{4'b1111, 32'd9,          32'd3,          32'd0,          32'd0,   1'b1, 1'b0, 1};
      vecs[5]  = '{4'b0000, 32'h0000F0F0,   32'h0000FF00,   32'h0000F000,   32'd0,   1'b0, 1'b0, 1};
      vecs[6]  = '{4'b0001, 32'h000000F0,   32'h0000000F,   32'h000000FF,   32'd0,   1'b0, 1'b0, 1};
      vecs[7]  = '{4'b0101, 32'h000000FF,   32'h0000000F,   32'h000000F0,   32'd0,   1'b0, 1'b0, 1};
      vecs[8]  = '{4'b0111, 32'd1,          32'hFFFFFFFF,   32'd0,          32'd0,   1'b1, 1'b0, 1};
      vecs[9]  = '{4'b0010, 32'hFFFFFFFF,   32'd1,          32'd0,          32'd0,   1'b1, 1'b0, 1};
      vecs[10] = '{4'b1000, 32'h00001234,   32'h00000100,   32'h00123400,   32'd0,   1'b0, 1'b0, 33};
      vecs[11] = '{4'b1000, 32'hFFFFFFFF,   32'd2,          32'hFFFFFFFE,   32'd0,   1'b0, 1'b0, 33};
      vecs[12] = '{4'b1010, 32'd100,        32'd7,          32'd14,         32'd2,   1'b0, 1'b0, 33};
      vecs[13] = '{4'b1010, 32'd100,        32'd0,          32'hFFFFFFFF,   32'd100, 1'b0, 1'b1, 1};
      vecs[14] = '{4'b0010, 32'd1,          32'd1,          32'd2,          32'd0,   1'b0, 1'b0, 1};
      vecs[15] = '{4'b1010, 32'd7,          32'd100,        32'd0,          32'd7,   1'b1, 1'b0, 33};
      vecs[16] = '{4'b1000, 32'd0,          32'd5,          32'd0,          32'd0,   1'b1, 1'b0, 33};
      vecs[17] = '{4'b1010, 32'hFFFFFFFF,   32'h00010000,   32'h0000FFFF,   32'h0000FFFF, 1'b0, 1'b0, 33};

      rst_n = 1'b1; inicio = 1'b0; control = 4'b0000; a = '0; b = '0;

      // Asynchronous reset before any clock edge
      #2 rst_n = 1'b0;
      #1;
      chk("rst_resultado", resultado, 32'd0);
      chk("rst_cero", {31'b0, cero}, 32'd0);
      chk("rst_listo", {31'b0, listo}, 32'd0);
      chk("rst_ocupado", {31'b0, ocupado}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      pulses = 0;
      repeat (5) begin
         @(negedge clk);
         if (listo) pulses++;
      end
      chk("idle_no_listo", pulses, 32'd0);

      for (int i = 0; i < 18; i++) run_vec(i, vecs[i]);

      // mul with inicio pulses and operand changes while busy
      @(negedge clk);
      control = 4'b1000; a = 32'h00001234; b = 32'h00000100; inicio = 1'b1;
      lat = 0; occ = 0; both = 1'b0;
      do begin
         @(posedge clk); #1;
         lat++;
         if (lat >= 2 && lat <= 20) begin
            inicio = lat[0]; control = 4'b0010; a = $urandom; b = $urandom;
         end else begin
            inicio = 1'b0;
         end
         if (ocupado) occ++;
         if (ocupado && listo) both = 1'b1;
      end while (!listo && lat < 100);
      chk("mulx_lat", lat, 32'd33);
      chk("mulx_res", resultado, 32'h00123400);
      chk("mulx_ocupado_cycles", occ, 32'd32);
      chk("mulx_overlap", {31'b0, both}, 32'd0);

      // Back-to-back single-cycle ops with inicio held high
      @(negedge clk);
      control = 4'b0010; a = 32'd7; b = 32'd5; inicio = 1'b1;
      @(negedge clk);
      chk("b2b_listo0", {31'b0, listo}, 32'd1);
      chk("b2b_res0", resultado, 32'd12);
      control = 4'b0110; a = 32'd5; b = 32'd5;
      @(negedge clk);
      chk("b2b_listo1", {31'b0, listo}, 32'd1);
      chk("b2b_res1", resultado, 32'd0);
      chk("b2b_cero1", {31'b0, cero}, 32'd1);
      control = 4'b0000; a = 32'd6; b = 32'd12;
      @(negedge clk);
      chk("b2b_listo2", {31'b0, listo}, 32'd1);
      chk("b2b_res2", resultado, 32'd4);
      inicio = 1'b0;
      @(negedge clk);
      chk("b2b_listo_end", {31'b0, listo}, 32'd0);

      // Reset ten cycles into a mul
      @(negedge clk);
      control = 4'b1000; a = 32'h00001234; b = 32'h00000100; inicio = 1'b1;
      @(posedge clk); #1 inicio = 1'b0;
      repeat (10) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("midrst_resultado", resultado, 32'd0);
      chk("midrst_ocupado", {31'b0, ocupado}, 32'd0);
      chk("midrst_listo", {31'b0, listo}, 32'd0);
      chk("midrst_cero", {31'b0, cero}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      pulses = 0;
      repeat (40) begin
         @(negedge clk);
         if (listo || ocupado) pulses++;
      end
      chk("midrst_no_listo", pulses, 32'd0);
      chk("midrst_res_hold", resultado, 32'd0);
      run_vec(100, '{4'b1000, 32'd3, 32'd4, 32'd12, 32'd0, 1'b0, 1'b0, 33});

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule

// File: doc/alu_multiciclo.md
# alu_multiciclo

Multi-cycle execution unit that sits directly downstream of the ALU control decoder in the MIPS datapath. It consumes the decoder's 4-bit operation code plus two operands and completes logic and add/sub/compare operations in one cycle. It completes multiply and divide iteratively over WIDTH cycles. A start/done handshake lets the control FSM stall the pipeline while a long operation is in flight.

## Interface
- WIDTH, 32, operand and result width in bits.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- inicio  in  1  start request; sampled on rising edge.
- control  in  4  operation code from the ALU control decoder.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- resultado  out  WIDTH  registered result.
- resto  out  WIDTH  division remainder; 0 for all other operations.
- cero  out  1  registered flag, 1 when resultado==0.
- div_cero  out  1  1 when the last completed operation was a divide by zero.
- ocupado  out  1  high while an iterative multiply or divide is in progress.
- listo  out  1  one-cycle completion pulse, one per accepted operation.

## Operation
- Codes:
  - 0010 add.
  - 0110 sub.
  - 0000 and.
  - 0001 or.
  - 0111 slt: signed compare, resultado = 1 if a<b, else 0.
  - 0101 xor.
  - 1100 nor.
  - 1000 mul: low WIDTH bits of product, unsigned shift-add; valid for two's complement.
  - 1010 div: unsigned restoring division; quotient to resultado, remainder to resto.
  - Any other code: resultado=0, completes as a single-cycle op.
- Arithmetic:
  - add/sub wrap modulo 2^WIDTH.
  - No overflow flag.
  - The multiply accumulator and the division partial remainder are each WIDTH+1 bits internally.
- States:
  - REPOSO (idle).
  - MUL.
  - DIV.
  - FIN: listo=1 for exactly this cycle.
- Acceptance:
  - inicio is accepted only in REPOSO or FIN.
  - On acceptance, a, b and control are captured; later input changes have no effect on the accepted op.
- State transitions:
  - REPOSO/FIN + inicio, single-cycle op → result registered, go to FIN.
  - REPOSO/FIN + inicio, div with b==0 → resultado = all ones, resto = a, div_cero=1, go to FIN.
  - REPOSO/FIN + inicio, mul → load operands, counter=WIDTH, go to MUL.
  - REPOSO/FIN + inicio, div with b!=0 → load operands, counter=WIDTH, go to DIV.
  - MUL/DIV → one iteration per cycle, counter decrements; at the last iteration, write resultado/resto/cero and go to FIN.
  - FIN without inicio → REPOSO.
- inicio in MUL/DIV is ignored; it is not queued.
- Output updates:
  - resultado, resto and cero update only at completion and hold until the next completion.
  - div_cero is set or cleared at every completion.
- ocupado = state is MUL or DIV.

## Timing
- Reset (asynchronous, any time, including mid-operation):
  - State goes to REPOSO.
  - resultado, resto, cero, div_cero, ocupado and listo all go to 0; note cero resets to 0 even though resultado=0.
  - The counter clears and the in-flight op is discarded with no listo.
- Single-cycle ops and divide-by-zero: inicio sampled at edge k → listo high, result valid, in the cycle after edge k (latency 1).
- mul/div:
  - inicio at edge k → ocupado high after edge k through edge k+WIDTH.
  - listo high and result valid in the cycle after edge k+WIDTH (latency WIDTH+1).
  - ocupado is high for exactly WIDTH cycles.
- Back-to-back: inicio high during FIN is accepted, so single-cycle ops can complete every cycle with listo held high continuously.
- listo and ocupado are never high simultaneously.

## Test plan
- Reset: drive rst_n=0 mid-cycle → all outputs 0 immediately; release, hold inicio=0 → stays REPOSO, listo never pulses.
- Single-cycle ops, each listo exactly 1 cycle after inicio:
  - add 7+5 → resultado=12, cero=0.
  - sub 5-5 → 0, cero=1.
  - slt a=0xFFFFFFFF, b=1 → 1.
  - nor 0,0 → 0xFFFFFFFF.
  - code 1111 → 0.
- mul 0x00001234 × 0x00000100 → 0x00123400, listo 33 cycles after inicio, ocupado high 32 cycles; inicio pulses and a/b changes during ocupado have no effect. Also 0xFFFFFFFF × 2 → 0xFFFFFFFE.
- div:
  - 100/7 → resultado=14, resto=2, div_cero=0, latency 33.
  - 100/0 → resultado=0xFFFFFFFF, resto=100, div_cero=1, latency 1.
  - Following add 1+1 → div_cero cleared.
- Back-to-back add, sub, and with inicio held high → listo high 3 consecutive cycles, results 12, 0, 4 for inputs (7,5),(5,5),(6,12).
- Reset asserted 10 cycles into a mul → outputs 0, no listo; subsequent mul 3×4 → 12 after 33 cycles.
